store_align: RTL and testbench
==============================

# store_align

Store-path byte-lane aligner: the write-side counterpart of the load sign-extension stage. It takes a register value, an address and a store width from the execute stage. It truncates the value to the requested width and shifts it onto the correct byte lanes. It then issues one or two word-aligned write beats with byte strobes to the data-memory port, under a valid/ready handshake on both sides.

## Interface
- `DATA_WIDTH`, 32: datapath width. Only 32 is supported, because lane logic uses `addr[1:0]`.
- `ADDR_WIDTH`, 32: byte-address width.

- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  store request present
- `req_ready`  out  1  block can accept a request (high only in IDLE)
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_data`  in  DATA_WIDTH  unaligned source register value
- `st_op`  in  3  store width: `ST_B`=3'b000, `ST_H`=3'b001, `ST_W`=3'b010 (`isa_shared`); other codes illegal
- `mem_valid`  out  1  write beat present
- `mem_ready`  in  1  memory accepts beat
- `mem_addr`  out  ADDR_WIDTH  word-aligned address (`[1:0]`=0)
- `mem_wdata`  out  DATA_WIDTH  lane-shifted data; non-strobed lanes are 0
- `mem_wstrb`  out  DATA_WIDTH/8  byte enables
- `done`  out  1  one-cycle pulse: store fully written
- `err`  out  1  one-cycle pulse: illegal `st_op`, or unsupported misalignment

## Operation
- Request is accepted when `req_valid && req_ready`. `req_addr`, `req_data` and `st_op` are latched; inputs are ignored afterwards.
- Width mask `m` is 4'b0001 for B, 4'b0011 for H, 4'b1111 for W. Offset `off = addr[1:0]`.
- Beat0 fields:
  - `mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}`
  - `mem_wstrb = (m<<off)[3:0]`
  - `mem_wdata = (data & bytemask(m)) << 8*off`, truncated to 32 bits
- Split condition: `(m<<off)[7:4] != 0`. When split, beat1 fields are:
  - `mem_addr = beat0 addr + 4`, modulo 2^ADDR_WIDTH
  - `mem_wstrb = (m<<off)[7:4]`
  - `mem_wdata = (data & bytemask(m)) >> 8*(4-off)`
- FSM states are IDLE, BEAT0 and BEAT1.
  - IDLE to BEAT0 on accept with a legal op and supported alignment.
  - IDLE to IDLE on accept with an illegal op or unsupported alignment. `err` pulses the following cycle.
  - BEAT0 to IDLE on `mem_valid && mem_ready` when there is no split.
  - BEAT0 to BEAT1 on `mem_valid && mem_ready` when there is a split.
  - BEAT1 to IDLE on `mem_valid && mem_ready`.
- `done` pulses in the cycle after the final beat handshake, which is also the cycle FSM re-enters IDLE.
- `err` and `done` are never both high. An erroring request produces no memory beat.
- `mem_valid` is high exactly in BEAT0 and BEAT1. `mem_addr`, `mem_wdata` and `mem_wstrb` are held stable while `mem_valid && !mem_ready`.
- Reset values: FSM=IDLE, `req_ready`=1, `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `done`=0, `err`=0.
- Reset mid-operation aborts the store. There is no `done` and no remaining beat; the state is IDLE on the cycle after reset.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- The request is accepted at edge N:
  - `mem_valid`=1 in cycle N+1.
  - With `mem_ready`=1 throughout, an aligned store has its handshake in N+1, `done` in N+2, and `req_ready`=1 in N+2.
  - A split store has beat1 in N+2 and `done` in N+3.
- Illegal or unsupported request accepted at N: `err`=1 in N+1, and `req_ready` stays high.
- Each cycle `mem_ready` is low adds one cycle per beat.
- Throughput is one store per 2 cycles (aligned) or 3 cycles (split). Back-to-back acceptance is not allowed while busy.

## Configuration
- `STORE_MISALIGNED_SPLIT_EN` defined: every legal op at any offset is performed, splitting into two beats when the split condition holds. `err` asserts only for illegal `st_op`.
- `STORE_MISALIGNED_SPLIT_EN` undefined: the BEAT1 state and its logic are not built.
  - Misaligned H (`addr[0]`=1) or misaligned W (`addr[1:0]`≠0) gives `err` and no beat.
  - B is always legal.

## Test plan
- SB, addr 0x1003, data 0xAABBCCDD, `mem_ready`=1 -> beat `mem_addr` 0x1000, `mem_wdata` 0xDD000000, `mem_wstrb` 4'b1000. `done` two cycles after accept.
- SW, addr 0x2000, data 0x12345678, `mem_ready` low 3 cycles -> beat is held stable (0x2000, 0x12345678, 4'b1111) for 4 cycles. `done` one cycle after the handshake, and `req_ready` low throughout.
- SW, addr 0x1002, data 0x11223344, macro defined -> beat0 0x1000/0x33440000/4'b1100, then beat1 0x1004/0x00001122/4'b0011, then `done`. Macro undefined -> `err` at N+1, `mem_valid` never asserts.
- SH, addr 0xFFFFFFFF, data 0x0000BEEF, macro defined -> beat0 0xFFFFFFFC/0xEF000000/4'b1000, beat1 0x00000000/0x000000BE/4'b0001.
- `st_op`=3'b011 at any address -> `err` pulse for one cycle, no `mem_valid`, no `done`, and `req_ready` remains 1.
- Split SW: hold `mem_ready`=0 in BEAT1 and assert `rst` -> next cycle `mem_valid`=0, all outputs at reset values, no `done`. A new SB is then accepted normally.

Source files
------------

// File: rtl/store_align_if.sv
// Store-path bundle between the execute stage, the aligner and the data-memory write port.
// The master modport is the environment side; the slave modport is the aligner side.
interface store_align_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [2:0]              st_op;
    logic                    mem_valid;
    logic                    mem_ready;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic                    done;
    logic                    err;

    modport master (
        output req_valid, req_addr, req_data, st_op, mem_ready,
        input  req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, st_op, mem_ready,
        output req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err
    );
endinterface

// File: rtl/store_align.sv
// Store byte-lane aligner: truncates, lane-shifts and issues one or two strobed write beats.
// Define STORE_MISALIGNED_SPLIT_EN to split misaligned stores across two words instead of erroring.
module store_align #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    store_align_if.slave bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0] ST_B = 3'b000;
    localparam logic [2:0] ST_H = 3'b001;
    localparam logic [2:0] ST_W = 3'b010;

`ifdef STORE_MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1} state_t;
`endif

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [1:0]              off;
    logic [3:0]              m;
    logic                    legal;
    logic                    unsupported;
    logic                    split;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [7:0]              strb_wide;
    logic [ADDR_WIDTH-1:0]   base_addr;

`ifdef STORE_MISALIGNED_SPLIT_EN
    logic [2*DATA_WIDTH-1:0] lane_wide;
    logic [ADDR_WIDTH-1:0]   hi_addr_q, hi_addr_d;
    logic [DATA_WIDTH-1:0]   hi_wdata_q, hi_wdata_d;
    logic [STRB_WIDTH-1:0]   hi_wstrb_q, hi_wstrb_d;
    logic                    split_q, split_d;
`else
    logic [DATA_WIDTH-1:0]   lane_wide;
`endif

    // Lane arithmetic for the request currently presented on the input side.
    always_comb begin
        off       = bus.req_addr[1:0];
        m         = 4'b0000;
        legal     = 1'b1;
        case (bus.st_op)
            ST_B:    m = 4'b0001;
            ST_H:    m = 4'b0011;
            ST_W:    m = 4'b1111;
            default: legal = 1'b0;
        endcase
        byte_mask = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
        strb_wide = {4'b0000, m} << off;
        split     = |strb_wide[7:4];
        base_addr = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
`ifdef STORE_MISALIGNED_SPLIT_EN
        lane_wide   = {{DATA_WIDTH{1'b0}}, bus.req_data & byte_mask} << {off, 3'b000};
        unsupported = 1'b0;
`else
        lane_wide   = (bus.req_data & byte_mask) << {off, 3'b000};
        // Any split covers misaligned W and H at offset 3; H at offset 1 stays in-word but is still misaligned.
        unsupported = split || (bus.st_op == ST_H && off[0]);
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
        hi_addr_d   = hi_addr_q;
        hi_wdata_d  = hi_wdata_q;
        hi_wstrb_d  = hi_wstrb_q;
        split_d     = split_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (legal && !unsupported) begin
                        state_d     = BEAT0;
                        mem_addr_d  = base_addr;
                        mem_wdata_d = lane_wide[DATA_WIDTH-1:0];
                        mem_wstrb_d = strb_wide[3:0];
`ifdef STORE_MISALIGNED_SPLIT_EN
                        hi_addr_d   = base_addr + ADDR_WIDTH'(4);
                        hi_wdata_d  = lane_wide[2*DATA_WIDTH-1:DATA_WIDTH];
                        hi_wstrb_d  = strb_wide[7:4];
                        split_d     = split;
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            BEAT0: begin
                if (bus.mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    if (split_q) begin
                        state_d     = BEAT1;
                        mem_addr_d  = hi_addr_q;
                        mem_wdata_d = hi_wdata_q;
                        mem_wstrb_d = hi_wstrb_q;
                    end else begin
                        state_d     = IDLE;
                        done_d      = 1'b1;
                        mem_addr_d  = '0;
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
`else
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
`endif
                end
            end
`ifdef STORE_MISALIGNED_SPLIT_EN
            BEAT1: begin
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                end
            end
`endif
            default: begin
                state_d     = IDLE;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                mem_wstrb_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
            hi_addr_q   <= '0;
            hi_wdata_q  <= '0;
            hi_wstrb_q  <= '0;
            split_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef STORE_MISALIGNED_SPLIT_EN
            hi_addr_q   <= hi_addr_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_wstrb_q  <= hi_wstrb_d;
            split_q     <= split_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.mem_valid = (state_q != IDLE);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_store_align.sv
// Directed bench for store_align: a byte-lane reference model fills a beat scoreboard at
// request time and each observed beat is compared against the head entry while it is presented.
module tb_store_align;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } beat_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    beat_t exp_q[$];

    store_align_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    store_align #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: walk source bytes onto destination lanes, spilling past lane 3 into a second word.
    task automatic pushExpected(input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] op, output bit is_err);
        int    n;
        int    lane;
        bit    spill;
        beat_t b0;
        beat_t b1;
        is_err = 1'b0;
        spill  = 1'b0;
        case (op)
            3'b000:  n = 1;
            3'b001:  n = 2;
            3'b010:  n = 4;
            default: begin n = 0; is_err = 1'b1; end
        endcase
`ifndef STORE_MISALIGNED_SPLIT_EN
        if (op == 3'b001 && addr[0]) is_err = 1'b1;
        if (op == 3'b010 && addr[1:0] != 2'b00) is_err = 1'b1;
`endif
        if (is_err) return;
        b0.addr  = {addr[31:2], 2'b00};
        b0.wdata = '0;
        b0.strb  = '0;
        b1.addr  = b0.addr + 32'd4;
        b1.wdata = '0;
        b1.strb  = '0;
        for (int i = 0; i < n; i++) begin
            lane = int'(addr[1:0]) + i;
            if (lane < 4) begin
                b0.wdata[8*lane +: 8] = data[8*i +: 8];
                b0.strb[lane]         = 1'b1;
            end else begin
                b1.wdata[8*(lane-4) +: 8] = data[8*i +: 8];
                b1.strb[lane-4]           = 1'b1;
                spill                     = 1'b1;
            end
        end
        exp_q.push_back(b0);
        if (spill) exp_q.push_back(b1);
    endtask

    task automatic checkBeat(input string tag);
        beat_t cur;
        cur = exp_q[0];
        checkOutput({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd1);
        checkOutput({tag, ".mem_addr"},  bus.mem_addr, cur.addr);
        checkOutput({tag, ".mem_wdata"}, bus.mem_wdata, cur.wdata);
        checkOutput({tag, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(cur.strb));
        checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'd0);
        checkOutput({tag, ".done"},      32'(bus.done), 32'd0);
        checkOutput({tag, ".err"},       32'(bus.err), 32'd0);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, ".mem_valid"}, 32'(bus.mem_valid), 32'd0);
        checkOutput({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, ".done"},      32'(bus.done), 32'd0);
        checkOutput({tag, ".err"},       32'(bus.err), 32'd0);
    endtask

    // One complete store: accept, then every beat with its stall count, then the done/err pulse.
    task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [2:0] op, input int stall0, input int stall1);
        bit is_err;
        int s;
        int b;
        pushExpected(addr, data, op, is_err);
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.st_op     = op;
        bus.req_valid = 1'b1;
        bus.mem_ready = 1'b0;
        checkOutput({tag, ".ready_at_accept"}, 32'(bus.req_ready), 32'd1);
        tick();
        // Junk request held while busy must be neither accepted nor leak into the beat.
        bus.req_addr = 32'hDEAD_BEEC;
        bus.req_data = $urandom;
        bus.st_op    = 3'b011;
        if (is_err) begin
            bus.req_valid = 1'b0;
            checkOutput({tag, ".err_pulse"}, 32'(bus.err), 32'd1);
            checkOutput({tag, ".err_valid"}, 32'(bus.mem_valid), 32'd0);
            checkOutput({tag, ".err_done"},  32'(bus.done), 32'd0);
            checkOutput({tag, ".err_ready"}, 32'(bus.req_ready), 32'd1);
            tick();
            checkIdle({tag, ".after_err"});
            return;
        end
        b = 0;
        while (exp_q.size() > 0) begin
            s = (b == 0) ? stall0 : stall1;
            for (int k = 0; k <= s; k++) begin
                checkBeat($sformatf("%s.beat%0d.c%0d", tag, b, k));
                bus.mem_ready = (k == s);
                if (k == s && exp_q.size() == 1) bus.req_valid = 1'b0;
                tick();
            end
            void'(exp_q.pop_front());
            b++;
        end
        bus.mem_ready = 1'b0;
        checkOutput({tag, ".done_pulse"}, 32'(bus.done), 32'd1);
        checkOutput({tag, ".done_ready"}, 32'(bus.req_ready), 32'd1);
        checkOutput({tag, ".done_valid"}, 32'(bus.mem_valid), 32'd0);
        checkOutput({tag, ".done_err"},   32'(bus.err), 32'd0);
        tick();
        checkIdle({tag, ".after_done"});
    endtask

    // Abort a store with reset after a given number of completed beats, with memory stalling.
    task automatic resetDuring(input string tag, input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] op, input int beats_before);
        bit is_err;
        pushExpected(addr, data, op, is_err);
        checkOutput({tag, ".legal"}, 32'(is_err), 32'd0);
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.st_op     = op;
        bus.req_valid = 1'b1;
        bus.mem_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        for (int b = 0; b < beats_before; b++) begin
            checkBeat($sformatf("%s.beat%0d", tag, b));
            bus.mem_ready = 1'b1;
            tick();
            bus.mem_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        checkBeat({tag, ".stalled"});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        checkIdle({tag, ".rst"});
        checkOutput({tag, ".rst.mem_addr"},  bus.mem_addr, 32'h0);
        checkOutput({tag, ".rst.mem_wdata"}, bus.mem_wdata, 32'h0);
        checkOutput({tag, ".rst.mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
        tick();
        checkIdle({tag, ".post_rst"});
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.st_op     = 3'b000;
        bus.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset released");
        checkIdle("reset");
        checkOutput("reset.mem_addr",  bus.mem_addr, 32'h0);
        checkOutput("reset.mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("reset.mem_wstrb", 32'(bus.mem_wstrb), 32'h0);

        applyStimulus("sb_1003",     32'h0000_1003, 32'hAABB_CCDD, 3'b000, 0, 0);
        applyStimulus("sw_stall",    32'h0000_2000, 32'h1234_5678, 3'b010, 3, 0);
        applyStimulus("sw_1002",     32'h0000_1002, 32'h1122_3344, 3'b010, 0, 0);
        applyStimulus("sh_wrap",     32'hFFFF_FFFF, 32'h0000_BEEF, 3'b001, 0, 0);
        applyStimulus("op_011",      32'h0000_0040, 32'h5555_AAAA, 3'b011, 0, 0);
        applyStimulus("sh_1002",     32'h0000_1002, 32'hCAFE_F00D, 3'b001, 1, 0);
        applyStimulus("sb_1001",     32'h0000_1001, 32'h0000_0077, 3'b000, 2, 0);
        applyStimulus("op_111",      32'h0000_3000, 32'h0123_4567, 3'b111, 0, 0);
        applyStimulus("sh_1001",     32'h0000_1001, 32'h9999_BEEF, 3'b001, 0, 0);
        applyStimulus("sw_split_st", 32'h0000_0103, 32'hA1B2_C3D4, 3'b010, 1, 2);
        applyStimulus("sh_0000",     32'h0000_0000, 32'hFFFF_1357, 3'b001, 0, 0);

`ifdef STORE_MISALIGNED_SPLIT_EN
        resetDuring("rst_beat1", 32'h0000_1002, 32'h1122_3344, 3'b010, 1);
`else
        resetDuring("rst_beat0", 32'h0000_2000, 32'h1122_3344, 3'b010, 0);
`endif
        applyStimulus("sb_after_rst", 32'h0000_4002, 32'h0000_00A5, 3'b000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
